// File: rtl/spi_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_pkg
// Purpose  : Frame layout and FSM state encoding for the 24-bit SPI
//            register protocol. The same layout is used by the master and by
//            the register target.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package spi_reg_pkg;

  // Frame layout: [23] R/nW (1 = read), [22:16] address, [15:0] data.
  localparam int FRAME_W  = 24;
  localparam int RW_BIT   = 23;
  localparam int ADDR_MSB = 22;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_slave_regbank.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_regbank
// Purpose  : Shadow and active register banks for the SPI register target.
//            A serial write lands in the shadow bank. io_update copies the
//            whole shadow bank into the active bank. A write that completes
//            on the same edge as io_update is forwarded into the active bank.
// Ports    : sclk, n_rst        clock / async active-low reset
//            we, waddr, wdata   shadow write port
//            raddr, rdata       combinational shadow read (0 if out of range)
//            io_update          shadow -> active copy strobe
//            active_regs        flattened active bank, reg k at [k*DATA_W +: DATA_W]
// Revision : 1.0  initial release
// ============================================================================
module spi_slave_regbank #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic                       sclk,
  input  logic                       n_rst,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [ADDR_W-1:0]          raddr,
  output logic [DATA_W-1:0]          rdata,
  input  logic                       io_update,
  output logic [NUM_REGS*DATA_W-1:0] active_regs
);

  logic [NUM_REGS*DATA_W-1:0] shadow_flat;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    logic              hit;
    logic [DATA_W-1:0] shadow_q;
    logic [DATA_W-1:0] active_q;

    assign hit = we && (32'(waddr) == k);

    always_ff @(posedge sclk or negedge n_rst) begin
      if (!n_rst) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        if (hit) begin
          shadow_q <= wdata;
        end
        // Forward a same-edge write so io_update never publishes stale data.
        if (io_update) begin
          active_q <= hit ? wdata : shadow_q;
        end
      end
    end

    assign shadow_flat[k*DATA_W +: DATA_W] = shadow_q;
    assign active_regs[k*DATA_W +: DATA_W] = active_q;
  end

  // An out-of-range address matches no entry and reads back as zero.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (32'(raddr) == k) begin
        rdata = shadow_flat[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_slave_reg.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_reg
// Purpose  : SPI register target. Deserializes 24-bit MOSI frames
//            (R/nW, address, data). Writes go to a shadow bank. Reads are
//            served on MISO, and io_update publishes shadow to active.
// Ports    : sclk         only clock (rise samples mosi, fall drives miso)
//            n_rst        async active-low reset
//            n_cs         frame select, active low
//            mosi / miso  serial data, MSB first
//            io_update    shadow -> active copy
//            active_regs  active bank, reg k at [k*DATA_W +: DATA_W]
//            wr_strobe    1-cycle pulse on completed shadow write
//            wr_addr      address of last completed write
//            addr_err     1-cycle pulse: completed frame out of range
//            frame_err    1-cycle pulse: short frame abort or extra bits
// Revision : 1.0  initial release
// ============================================================================
module spi_slave_reg
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W   = ADDR_MSB - ADDR_LSB + 1,
  parameter int DATA_W   = DATA_MSB - DATA_LSB + 1,
  parameter int NUM_REGS = 8
) (
  input  logic                       sclk,
  input  logic                       n_rst,
  input  logic                       n_cs,
  input  logic                       mosi,
  output logic                       miso,
  input  logic                       io_update,
  output logic [NUM_REGS*DATA_W-1:0] active_regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       addr_err,
  output logic                       frame_err
);

  localparam int FRM_W = 1 + ADDR_W + DATA_W;
  localparam int HDR_W = 1 + ADDR_W;
  // Only the bits still needed at the header or final edge are kept.
  localparam int SH_W  = ((HDR_W > DATA_W) ? HDR_W : DATA_W) - 1;
  localparam int CNT_W = $clog2(FRM_W + 2);

  localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] CNT_FRM_LAST = CNT_W'(FRM_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRM_W);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(FRM_W + 1);

  spi_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;        // bits seen in the current frame
  logic [SH_W-1:0]   shreg;
  logic [HDR_W-1:0]  hdr_word;
  logic [DATA_W-1:0] data_word;
  logic [ADDR_W-1:0] addr_q;
  logic              is_read;
  logic [DATA_W-1:0] rd_sr;
  logic [DATA_W-1:0] rd_data;
  logic              bit_en, hdr_last, frm_last, abort, extra;
  logic              in_range, wr_fire, aerr_fire, ferr_fire;

  // Header and data words include the bit arriving on this edge.
  assign hdr_word  = {shreg[HDR_W-2:0], mosi};
  assign data_word = {shreg[DATA_W-2:0], mosi};
  assign in_range  = 32'(addr_q) < NUM_REGS;

  always_ff @(posedge sclk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bit_en    = !n_cs && (state != DONE);
    hdr_last  = bit_en && (cnt == CNT_HDR_LAST);
    frm_last  = bit_en && (cnt == CNT_FRM_LAST);
    abort     = n_cs && ((state == HDR) || (state == DATA));
    // Only the first surplus bit is flagged. After it the counter sits at saturation.
    extra     = !n_cs && (state == DONE) && (cnt == CNT_FULL);
    case (state)
      IDLE: if (!n_cs) state_nxt = HDR;
      HDR:  if (n_cs) state_nxt = IDLE; else if (hdr_last) state_nxt = DATA;
      DATA: if (n_cs) state_nxt = IDLE; else if (frm_last) state_nxt = DONE;
      DONE: if (n_cs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_fire   = frm_last && !is_read && in_range;
  assign aerr_fire = frm_last && !in_range;
  assign ferr_fire = abort || extra;

  always_ff @(posedge sclk or negedge n_rst) begin
    if (!n_rst) begin
      cnt       <= '0;
      shreg     <= '0;
      addr_q    <= '0;
      is_read   <= 1'b0;
      rd_sr     <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      addr_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= wr_fire;
      addr_err  <= aerr_fire;
      frame_err <= ferr_fire;
      if (n_cs) begin
        cnt <= '0;
      end else if (cnt != CNT_SAT) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (bit_en) begin
        shreg <= {shreg[SH_W-2:0], mosi};
      end
      if (hdr_last) begin
        is_read <= hdr_word[HDR_W-1];
        addr_q  <= hdr_word[ADDR_W-1:0];
        rd_sr   <= rd_data;
      end else if (state == DATA) begin
        // Pre-shift so the next falling edge presents the following bit.
        rd_sr <= rd_sr << 1;
      end
      if (wr_fire) begin
        wr_addr <= addr_q;
      end
    end
  end

  // Falling-edge driver gives the master a full half-cycle of setup.
  always_ff @(negedge sclk or negedge n_rst) begin
    if (!n_rst) begin
      miso <= 1'b0;
    end else begin
      miso <= ((state == DATA) && is_read) ? rd_sr[DATA_W-1] : 1'b0;
    end
  end

  spi_slave_regbank #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regbank (
    .sclk        (sclk),
    .n_rst       (n_rst),
    .we          (wr_fire),
    .waddr       (addr_q),
    .wdata       (data_word),
    .raddr       (hdr_word[ADDR_W-1:0]),
    .rdata       (rd_data),
    .io_update   (io_update),
    .active_regs (active_regs)
  );

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_reg
// Purpose  : Self-checking bench for spi_slave_reg against a frame-level
//            register model (shadow/active arrays).
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave_reg;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int BANK_W   = NUM_REGS * DATA_W;

  logic sclk      = 1'b0;
  logic n_rst     = 1'b0;
  logic n_cs      = 1'b1;
  logic mosi      = 1'b0;
  logic io_update = 1'b0;
  logic miso, wr_strobe, addr_err, frame_err;
  logic [ADDR_W-1:0] wr_addr;
  logic [BANK_W-1:0] active_regs;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] m_shadow [NUM_REGS];
  logic [DATA_W-1:0] m_active [NUM_REGS];
  logic [ADDR_W-1:0] m_wr_addr;

  spi_slave_reg #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .sclk        (sclk),
    .n_rst       (n_rst),
    .n_cs        (n_cs),
    .mosi        (mosi),
    .miso        (miso),
    .io_update   (io_update),
    .active_regs (active_regs),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .addr_err    (addr_err),
    .frame_err   (frame_err)
  );

  always #5 sclk = ~sclk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BANK_W-1:0] model_bank();
    logic [BANK_W-1:0] v;
    for (int k = 0; k < NUM_REGS; k++) v[k*DATA_W +: DATA_W] = m_active[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
    m_wr_addr = '0;
  endtask

  task automatic pulse_update(input string tag);
    io_update = 1'b1;
    @(posedge sclk); #1;
    io_update = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) m_active[k] = m_shadow[k];
    check_eq({tag, "/bank"}, active_regs, model_bank());
  endtask

  // Sends nbits of a frame (nbits>24 appends random surplus bits), then one
  // n_cs-high cycle. Sample i is taken just after the rising edge of bit i.
  task automatic do_frame(input string tag, input bit rd, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input int nbits = 24, input bit upd = 1'b0);
    logic [23:0]       frame;
    logic [31:0]       g_miso, g_wr, g_aerr, g_ferr;
    logic [31:0]       e_miso, e_wr, e_aerr, e_ferr;
    logic [DATA_W-1:0] rval;
    bit                inr;
    frame  = {rd, addr, data};
    inr    = int'(addr) < NUM_REGS;
    rval   = inr ? m_shadow[addr[2:0]] : '0;
    g_miso = '0; g_wr = '0; g_aerr = '0; g_ferr = '0;
    e_miso = '0; e_wr = '0; e_aerr = '0; e_ferr = '0;
    if (nbits >= 24) begin
      if (rd) for (int i = 8; i < 24; i++) e_miso[i] = rval[23-i];
      if (!rd && inr) e_wr[23] = 1'b1;
      if (!inr) e_aerr[23] = 1'b1;
      if (nbits > 24) e_ferr[24] = 1'b1;
    end else begin
      e_ferr[nbits] = 1'b1;
    end
    for (int i = 0; i <= nbits; i++) begin
      if (i < nbits) begin
        n_cs = 1'b0;
        mosi = (i < 24) ? frame[23-i] : 1'($urandom);
      end else begin
        n_cs = 1'b1;
        mosi = 1'b0;
      end
      io_update = upd && (i == 23);
      @(posedge sclk); #1;
      g_miso[i] = miso;
      g_wr[i]   = wr_strobe;
      g_aerr[i] = addr_err;
      g_ferr[i] = frame_err;
    end
    io_update = 1'b0;
    if (nbits >= 24 && !rd && inr) begin
      m_shadow[addr[2:0]] = data;
      m_wr_addr = addr;
    end
    if (upd) for (int k = 0; k < NUM_REGS; k++) m_active[k] = m_shadow[k];
    check_eq({tag, "/miso"}, g_miso, e_miso);
    check_eq({tag, "/wr_strobe"}, g_wr, e_wr);
    check_eq({tag, "/addr_err"}, g_aerr, e_aerr);
    check_eq({tag, "/frame_err"}, g_ferr, e_ferr);
    check_eq({tag, "/wr_addr"}, wr_addr, m_wr_addr);
    check_eq({tag, "/bank"}, active_regs, model_bank());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    model_reset();
    repeat (3) @(posedge sclk);
    #1;
    check_eq("rst/miso", miso, 1'b0);
    check_eq("rst/wr_strobe", wr_strobe, 1'b0);
    check_eq("rst/wr_addr", wr_addr, '0);
    check_eq("rst/addr_err", addr_err, 1'b0);
    check_eq("rst/frame_err", frame_err, 1'b0);
    check_eq("rst/bank", active_regs, model_bank());
    @(negedge sclk);
    n_rst = 1'b1;
    @(posedge sclk); #1;

    do_frame("wr3", 1'b0, 7'h03, 16'hBEEF);
    check_eq("wr3/reg3_pre_update", active_regs[3*DATA_W +: DATA_W], 16'h0000);
    pulse_update("upd1");
    check_eq("upd1/reg3", active_regs[3*DATA_W +: DATA_W], 16'hBEEF);
    do_frame("rd3", 1'b1, 7'h03, 16'h0000);
    do_frame("rd3_again", 1'b1, 7'h03, 16'h0000);

    do_frame("wr_oor", 1'b0, 7'h10, 16'h1234);
    do_frame("rd_oor", 1'b1, 7'h10, 16'h0000);

    do_frame("abort12", 1'b0, 7'h02, 16'hA5A5, 12);
    do_frame("wr2", 1'b0, 7'h02, 16'h5A5A);
    do_frame("rd2", 1'b1, 7'h02, 16'h0000);

    do_frame("extra_bits", 1'b0, 7'h01, 16'h1111, 26);
    do_frame("rd1", 1'b1, 7'h01, 16'h0000);

    for (int n = 0; n < 15; n++) begin
      a = 7'($urandom_range(0, NUM_REGS - 1));
      d = 16'($urandom);
      do_frame("rnd_wr", 1'b0, a, d);
      do_frame("rnd_rd", 1'b1, a, 16'h0000);
    end

    do_frame("wr5_upd", 1'b0, 7'h05, 16'hC3A5, 24, 1'b1);
    check_eq("wr5_upd/reg5", active_regs[5*DATA_W +: DATA_W], 16'hC3A5);

    // Reset in the middle of a frame discards it and clears both banks.
    for (int i = 0; i < 10; i++) begin
      n_cs = 1'b0;
      mosi = 1'($urandom);
      @(posedge sclk); #1;
    end
    n_rst = 1'b0;
    #1;
    model_reset();
    check_eq("midrst/bank", active_regs, model_bank());
    check_eq("midrst/wr_addr", wr_addr, m_wr_addr);
    check_eq("midrst/miso", miso, 1'b0);
    n_cs = 1'b1;
    mosi = 1'b0;
    @(negedge sclk);
    n_rst = 1'b1;
    @(posedge sclk); #1;
    check_eq("midrst/frame_err", frame_err, 1'b0);
    do_frame("rd5_after_rst", 1'b1, 7'h05, 16'h0000);
    do_frame("wr6_after_rst", 1'b0, 7'h06, 16'h0F0F);
    do_frame("rd6_after_rst", 1'b1, 7'h06, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
